// File: rtl/inert_pkg.sv
// Shared register map and command-frame layout for the inertial-sensor SPI responder.
package inert_pkg;

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHOAMI    = 7'h0F;
  localparam logic [6:0] ADDR_CTRL1     = 7'h10;
  localparam logic [6:0] ADDR_CTRL2     = 7'h11;
  localparam logic [6:0] ADDR_CTRL3     = 7'h14;
  localparam logic [6:0] ADDR_PTCH_L    = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H    = 7'h23;
  localparam logic [6:0] ADDR_AZ_L      = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H      = 7'h2D;

  typedef struct packed {
    logic       rd;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_cmd_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer with an extra flop for edge detection; level and
// single-clk rise/fall pulses all live in the clk domain.
module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] sync;

  // Reset low: a pin already low at release never produces a fall pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b000;
    else        sync <= {sync[1:0], din};
  end

  assign lvl  = sync[1];
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

endmodule

// File: rtl/inert_spi_resp.sv
// SPI mode-0 responder emulating the inertial sensor: 16-bit command frames,
// small config register file, latched pitch-rate/AZ samples and a new-sample INT.
module inert_spi_resp
  import inert_pkg::*;
#(
  parameter logic [7:0] WHOAMI     = 8'h6A,
  parameter int         INT_EN_BIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] az,
  input  logic        smpl_vld
);

  logic        sclk_lvl_unused, sclk_rise, sclk_fall;
  logic        ss_lvl, ss_rise, ss_fall;
  logic [1:0]  mosi_sync;
  logic        frame_act;
  logic [15:0] rx;
  logic [4:0]  cnt;
  logic [7:0]  tx;
  logic [7:0]  int1_ctrl, ctrl1, ctrl2, ctrl3;
  logic [15:0] ptch_q, az_q, ptch_pend, az_pend;
  logic        pend, cap_q, rd_clr_q;
  logic [7:0]  rd_data;
  logic        commit, wr_en, rd_done;
  spi_cmd_t    cmd;

  spi_edge_sync u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(SCLK),
    .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync u_ss_sync (
    .clk(clk), .rst_n(rst_n), .din(SS_n),
    .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  // Same depth as the SCLK path, so the bit is aligned with the rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= 2'b00;
    else        mosi_sync <= {mosi_sync[0], MOSI};
  end

  assign cmd = rx;

  // Only a fall seen after reset opens a frame; a frame in flight at release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_act <= 1'b0;
      rx        <= '0;
      cnt       <= '0;
      tx        <= '0;
    end else if (ss_fall) begin
      frame_act <= 1'b1;
      cnt       <= '0;
      tx        <= '0;
    end else if (ss_rise) begin
      frame_act <= 1'b0;
      cnt       <= '0;
    end else if (frame_act) begin
      if (sclk_rise && cnt != 5'd16) begin
        rx  <= {rx[14:0], mosi_sync[1]};
        cnt <= cnt + 5'd1;
      end
      if (sclk_fall) begin
        if (cnt == 5'd8)     tx <= rx[7] ? rd_data : 8'h00;
        else if (cnt > 5'd8) tx <= {tx[6:0], 1'b0};
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rx[6:0])
      ADDR_INT1_CTRL: rd_data = int1_ctrl;
      ADDR_WHOAMI:    rd_data = WHOAMI;
      ADDR_CTRL1:     rd_data = ctrl1;
      ADDR_CTRL2:     rd_data = ctrl2;
      ADDR_CTRL3:     rd_data = ctrl3;
      ADDR_PTCH_L:    rd_data = ptch_q[7:0];
      ADDR_PTCH_H:    rd_data = ptch_q[15:8];
      ADDR_AZ_L:      rd_data = az_q[7:0];
      ADDR_AZ_H:      rd_data = az_q[15:8];
      default:        rd_data = 8'h00;
    endcase
  end

  assign commit  = ss_rise & frame_act & (cnt == 5'd16);
  assign wr_en   = commit & ~cmd.rd;
  assign rd_done = commit & cmd.rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_ctrl <= '0;
      ctrl1     <= '0;
      ctrl2     <= '0;
      ctrl3     <= '0;
      rd_clr_q  <= 1'b0;
    end else begin
      rd_clr_q <= rd_done && (cmd.addr == ADDR_AZ_H);
      if (wr_en) begin
        case (cmd.addr)
          ADDR_INT1_CTRL: int1_ctrl <= cmd.data;
          ADDR_CTRL1:     ctrl1     <= cmd.data;
          ADDR_CTRL2:     ctrl2     <= cmd.data;
          ADDR_CTRL3:     ctrl3     <= cmd.data;
          default:        ;
        endcase
      end
    end
  end

  // Samples arriving mid-frame are parked and applied at SS_n rise so served bytes stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_q    <= '0;
      az_q      <= '0;
      ptch_pend <= '0;
      az_pend   <= '0;
      pend      <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      cap_q <= 1'b0;
      if (smpl_vld && ss_lvl) begin
        ptch_q <= ptch_rt;
        az_q   <= az;
        pend   <= 1'b0;
        cap_q  <= 1'b1;
      end else begin
        if (smpl_vld) begin
          ptch_pend <= ptch_rt;
          az_pend   <= az;
          pend      <= 1'b1;
        end
        if (ss_rise && pend) begin
          ptch_q <= ptch_pend;
          az_q   <= az_pend;
          pend   <= 1'b0;
          cap_q  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               INT <= 1'b0;
    else if (cap_q && int1_ctrl[INT_EN_BIT]) INT <= 1'b1;
    else if (rd_clr_q)                        INT <= 1'b0;
  end

  assign MISO = ~SS_n & tx[7];

endmodule

// File: tb/tb_inert_spi_resp.sv
// Directed bench for inert_spi_resp: acts as SPI master, keeps a register-level
// model of the sensor and checks every sampled MISO bit plus INT around each frame.
module tb_inert_spi_resp;

  localparam int HALF = 8;

  logic        clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [15:0] ptch_rt = '0, az = '0;
  logic        MISO, INT;

  int          n_chk = 0, n_err = 0;
  logic [15:0] exp_frame = '0;
  int          cur_bit = 15;
  logic [15:0] got;

  logic [7:0]  m_rw [0:127];
  logic [15:0] m_ptch, m_az, m_pp, m_pa;
  logic        m_pend, m_int, m_in_frame;

  inert_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .ptch_rt(ptch_rt), .az(az), .smpl_vld(smpl_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Master samples MISO on each SCLK rise; the expected frame comes from the model.
  always @(posedge SCLK)
    if (!SS_n) chk("miso_bit", {15'd0, MISO}, {15'd0, exp_frame[cur_bit]});

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_rw[i] = 8'h00;
    m_ptch = '0; m_az = '0; m_pp = '0; m_pa = '0;
    m_pend = 1'b0; m_int = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    case (a)
      7'h0F:                      return 8'h6A;
      7'h22:                      return m_ptch[7:0];
      7'h23:                      return m_ptch[15:8];
      7'h2C:                      return m_az[7:0];
      7'h2D:                      return m_az[15:8];
      7'h0D, 7'h10, 7'h11, 7'h14: return m_rw[a];
      default:                    return 8'h00;
    endcase
  endfunction

  task automatic pulse(input logic [15:0] p, input logic [15:0] a);
    ptch_rt = p; az = a; smpl_vld = 1'b1;
    nclk(1);
    smpl_vld = 1'b0;
    if (m_in_frame) begin
      m_pend = 1'b1; m_pp = p; m_pa = a;
    end else begin
      m_ptch = p; m_az = a;
      if (m_rw[7'h0D][1]) m_int = 1'b1;
    end
    nclk(1);
    chk("int_smpl", {15'd0, INT}, {15'd0, m_int});
  endtask

  task automatic send_bit(input logic b, input int idx, output logic m);
    MOSI = b;
    nclk(HALF);
    cur_bit = idx;
    SCLK = 1'b1;
    m = MISO;
    nclk(HALF);
    SCLK = 1'b0;
  endtask

  task automatic frame(input logic [15:0] c, input int nbits, input logic smpl_mid,
                       input logic [15:0] p, input logic [15:0] a, output logic [15:0] rd);
    logic m;
    rd = '0;
    exp_frame = c[15] ? {8'h00, m_read(c[14:8])} : 16'h0000;
    m_in_frame = 1'b1;
    SS_n = 1'b0;
    nclk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (smpl_mid && i == 4) pulse(p, a);
      send_bit(c[15-i], 15 - i, m);
      rd = {rd[14:0], m};
    end
    nclk(HALF);
    chk("int_pre_rise", {15'd0, INT}, {15'd0, m_int});
    SS_n = 1'b1;
    m_in_frame = 1'b0;
    if (nbits == 16) begin
      if (!c[15]) begin
        if (c[14:8] == 7'h0D || c[14:8] == 7'h10 || c[14:8] == 7'h11 || c[14:8] == 7'h14)
          m_rw[c[14:8]] = c[7:0];
      end else if (c[14:8] == 7'h2D) m_int = 1'b0;
    end
    if (m_pend) begin
      m_ptch = m_pp; m_az = m_pa; m_pend = 1'b0;
      if (m_rw[7'h0D][1]) m_int = 1'b1;
    end
    nclk(HALF);
    chk("int_post_rise", {15'd0, INT}, {15'd0, m_int});
  endtask

  initial begin
    logic m;
    m_reset();
    m_in_frame = 1'b0;
    nclk(4);
    #1;
    chk("rst_miso", {15'd0, MISO}, 16'h0000);
    chk("rst_int", {15'd0, INT}, 16'h0000);
    rst_n = 1'b1;
    nclk(4);

    // WHO_AM_I and reset sample value
    frame(16'h8F00, 16, 1'b0, '0, '0, got);
    chk("whoami_b1", {8'h00, got[15:8]}, 16'h0000);
    chk("whoami", {8'h00, got[7:0]}, 16'h006A);
    frame(16'hAD00, 16, 1'b0, '0, '0, got);
    chk("az_h_rst", {8'h00, got[7:0]}, 16'h0000);

    // INT enable, sample capture and readback
    frame(16'h0D02, 16, 1'b0, '0, '0, got);
    pulse(16'h1234, 16'hFEDC);
    chk("int_set_lit", {15'd0, INT}, 16'h0001);
    frame(16'hA200, 16, 1'b0, '0, '0, got);
    chk("ptch_l", {8'h00, got[7:0]}, 16'h0034);
    frame(16'hA300, 16, 1'b0, '0, '0, got);
    chk("ptch_h", {8'h00, got[7:0]}, 16'h0012);
    frame(16'hAC00, 16, 1'b0, '0, '0, got);
    chk("az_l", {8'h00, got[7:0]}, 16'h00DC);
    frame(16'hAD00, 16, 1'b0, '0, '0, got);
    chk("az_h", {8'h00, got[7:0]}, 16'h00FE);
    chk("int_clr_lit", {15'd0, INT}, 16'h0000);

    // Sample arriving mid-frame is deferred to SS_n rise
    frame(16'hA200, 16, 1'b1, 16'hAAAA, 16'h5555, got);
    chk("ptch_l_old", {8'h00, got[7:0]}, 16'h0034);
    chk("int_defer_lit", {15'd0, INT}, 16'h0001);
    frame(16'hA200, 16, 1'b0, '0, '0, got);
    chk("ptch_l_new", {8'h00, got[7:0]}, 16'h00AA);

    // Aborted write, then full write
    frame(16'h1055, 10, 1'b0, '0, '0, got);
    frame(16'h9000, 16, 1'b0, '0, '0, got);
    chk("abort_no_wr", {8'h00, got[7:0]}, 16'h0000);
    frame(16'h1055, 16, 1'b0, '0, '0, got);
    frame(16'h9000, 16, 1'b0, '0, '0, got);
    chk("ctrl1_wr", {8'h00, got[7:0]}, 16'h0055);

    // Writes to RO and unmapped addresses are ignored
    frame(16'h0F00, 16, 1'b0, '0, '0, got);
    frame(16'h7FFF, 16, 1'b0, '0, '0, got);
    frame(16'h8F00, 16, 1'b0, '0, '0, got);
    chk("whoami_ro", {8'h00, got[7:0]}, 16'h006A);
    frame(16'hFF00, 16, 1'b0, '0, '0, got);
    chk("unmapped", {8'h00, got[7:0]}, 16'h0000);

    // Reset mid-frame; remainder of that frame must be ignored
    chk("int_before_rst", {15'd0, INT}, 16'h0001);
    exp_frame = 16'h0000;
    m_in_frame = 1'b1;
    SS_n = 1'b0;
    nclk(HALF);
    for (int i = 0; i < 5; i++) send_bit(got[0] ^ 1'b0 ? 1'b0 : (16'h10AA >> (15 - i)) & 1'b1, 15 - i, m);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_miso", {15'd0, MISO}, 16'h0000);
    chk("rst_mid_int", {15'd0, INT}, 16'h0000);
    m_reset();
    nclk(3);
    rst_n = 1'b1;
    for (int i = 5; i < 16; i++) send_bit((16'h10AA >> (15 - i)) & 1'b1, 15 - i, m);
    nclk(HALF);
    SS_n = 1'b1;
    m_in_frame = 1'b0;
    nclk(HALF);
    chk("int_after_rst", {15'd0, INT}, 16'h0000);
    frame(16'h9000, 16, 1'b0, '0, '0, got);
    chk("rst_no_wr", {8'h00, got[7:0]}, 16'h0000);
    frame(16'h1133, 16, 1'b0, '0, '0, got);
    frame(16'h9100, 16, 1'b0, '0, '0, got);
    chk("post_rst_wr", {8'h00, got[7:0]}, 16'h0033);
    frame(16'h8F00, 16, 1'b0, '0, '0, got);
    chk("post_rst_whoami", {8'h00, got[7:0]}, 16'h006A);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
